// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter
//   Two requesters share one bit-serial adder. A round-robin arbiter grants
//   one requester in IDLE and captures its operands. The sum is then formed
//   LSB first, one full-adder step per clock, over WIDTH cycles. The result
//   is published with a one-cycle done pulse.
//
// Ports
//   clk_in   : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   req[1:0] : pending request per requester
//   a0,b0    : requester 0 operands (unsigned, WIDTH bits)
//   a1,b1    : requester 1 operands (unsigned, WIDTH bits)
//   ack[1:0] : one-cycle pulse when a requester's operands are captured
//   busy     : high while not IDLE
//   done     : one-cycle pulse, sum/done_id valid
//   done_id  : requester that owns the current result
//   sum      : last completed result (WIDTH+1 bits), held until next done
module serial_add_arbiter #(
  parameter int WIDTH = 10
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       ack,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH:0]   sum
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_q, grant_d;
  logic             rr_q, rr_d;
  logic [1:0]       ack_q, ack_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic [WIDTH:0]   sum_q, sum_d;

  // Returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  always_comb begin
    logic       gnt;
    logic [1:0] fa;
    gnt       = 1'b0;
    fa        = 2'b00;
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    ack_d     = 2'b00;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    sum_d     = sum_q;

    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          // With both pending the pointer decides; otherwise req[1] is the
          // index of the single requester.
          gnt      = (req == 2'b11) ? rr_q : req[1];
          grant_d  = gnt;
          rr_d     = ~gnt;
          a_sh_d   = gnt ? a1 : a0;
          b_sh_d   = gnt ? b1 : b0;
          sum_sh_d = '0;
          carry_d  = 1'b0;
          cnt_d    = '0;
          ack_d    = gnt ? 2'b10 : 2'b01;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        fa       = full_add(a_sh_q[0], b_sh_q[0], carry_q);
        sum_sh_d = {fa[0], sum_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa[1];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Last bit: fold the final carry and this bit straight into sum
          // rather than waiting another cycle for sum_sh to settle.
          sum_d     = {fa[1], fa[0], sum_sh_q[WIDTH-1:1]};
          done_id_d = grant_q;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      grant_q   <= 1'b0;
      rr_q      <= 1'b0;
      ack_q     <= 2'b00;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_sh_q  <= sum_sh_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      sum_q     <= sum_d;
    end
  end

  assign ack     = ack_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign done_id = done_id_q;
  assign sum     = sum_q;

endmodule

// File: doc/serial_add_arbiter.md
SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, giving the operand width in bits.
REQ-002 The block SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port req, input, 2 bits: req[i] high means requester i has an addition pending.
REQ-005 The block SHALL have ports a0 and b0, input, WIDTH bits each: requester 0 operands, unsigned.
REQ-006 The block SHALL have ports a1 and b1, input, WIDTH bits each: requester 1 operands, unsigned.
REQ-007 The block SHALL have port ack, output, 2 bits: one-cycle pulse on ack[i] when requester i's operands are captured.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port done_id, output, 1 bit: index of the requester owning the current result.
REQ-011 The block SHALL have port sum, output, WIDTH+1 bits: the last completed result, held until the next done.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 The arithmetic SHALL be one 1-bit full adder plus a carry flop, used once per cycle, LSB first; no parallel adder.
REQ-014 In IDLE with req nonzero at an edge, the block SHALL grant one requester, latch its a/b into shift registers, clear carry and the bit counter, pulse ack[grant] in the following cycle, and enter SHIFT.
REQ-015 When only one req bit is high, that requester SHALL be granted.
REQ-016 When both req bits are high, the requester selected by the round-robin pointer SHALL be granted; the pointer SHALL then point to the other requester.
REQ-017 A grant to a single requester SHALL also set the pointer to the other requester.
REQ-018 In SHIFT, each edge SHALL add the operand LSBs plus carry, shift the result bit into sum_shift MSB-ward, shift the operands right, and increment the bit counter.
REQ-019 After exactly WIDTH SHIFT edges, the final carry SHALL become sum[WIDTH], sum SHALL be updated in full, done_id SHALL be set to the grant, and the state SHALL become DONE.
REQ-020 In DONE, done SHALL be high for exactly one cycle; the next edge SHALL return the state to IDLE.
REQ-021 Latency: done SHALL rise WIDTH cycles after ack rises; the next grant SHALL be possible at the first IDLE edge.
REQ-022 req SHALL be ignored outside IDLE; operand changes after capture SHALL have no effect on the result.
REQ-023 A req still high in IDLE after its ack SHALL be treated as a new request.
REQ-024 The result SHALL be exact: sum = a + b with no overflow possible, because sum is WIDTH+1 bits.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap during an operation.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, ack=0, busy=0, done=0, done_id=0, sum=0, carry=0, counter=0, and pointer set to requester 0.
REQ-027 A reset asserted mid-SHIFT or in DONE SHALL abort the operation with no done pulse; the aborted requester SHALL receive no result.
REQ-028 After rst_n rises, the first edge SHALL be able to grant a request.

Verification (WIDTH=10)
REQ-029 Single request: req=01, a0=5, b0=3 -> ack=01 for 1 cycle; 10 cycles later done=1, sum=8, done_id=0.
REQ-030 Simultaneous requests after reset: req=11, a0=100, b0=200, a1=7, b1=9 -> requester 0 served first (sum=300, done_id=0), then requester 1 (sum=16, done_id=1).
REQ-031 Maximum operands: a1=1023, b1=1023 -> sum=2046, sum[10]=1.
REQ-032 Round-robin fairness: req held at 11 for four operations -> done_id sequence 0,1,0,1; busy low exactly one cycle between operations.
REQ-033 Reset mid-operation: rst_n low at bit 5 of SHIFT -> outputs zero immediately, no done; a new req=10 after release -> correct sum, done_id=1.
REQ-034 Operand change: a0 changed during SHIFT -> sum still equals the captured operands.
